// File: rtl/serial_arith_pkg.sv
// Shared definitions for the digit-serial add/subtract datapath: FSM encoding
// and elaboration-time helpers for the digit count and counter width.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-digit operation still needs a 1-bit counter to exist.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_digit_adder.sv
// Combinational DIGIT-bit ripple slice. Exposes the carry into the slice MSB so
// the caller can derive signed overflow the same way for any digit size.
module serial_digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
            assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout     = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Handshaked digit-serial adder/subtractor: DIGIT bits per clock, LSB first,
// registered carry; results update only when an operation completes.
module serial_addsub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int N  = num_digits(WIDTH, DIGIT);
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0]       dig_s;
    logic                   dig_cout;
    logic                   dig_cmsb;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_shift;

    serial_digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a        (sa_q[DIGIT-1:0]),
        .b        (sb_q[DIGIT-1:0]),
        .cin      (carry_q),
        .s        (dig_s),
        .cout     (dig_cout),
        .c_msb_in (dig_cmsb)
    );

    // New digit enters at the MSB end; after N shifts the first digit sits at bit 0.
    assign res_cat   = {dig_s, res_q};
    assign res_shift = res_cat[WIDTH+DIGIT-1:DIGIT];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B and seed the carry.
                    sa_d    = A;
                    sb_d    = sub ? ~B : B;
                    carry_d = sub;
                    cnt_d   = CNT_LAST;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d    = sa_q >> DIGIT;
                sb_d    = sb_q >> DIGIT;
                res_d   = res_shift;
                carry_d = dig_cout;
                if (cnt_q == '0) begin
                    sum_d   = res_shift;
                    cout_d  = dig_cout;
                    ovf_d   = dig_cmsb ^ dig_cout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready     = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and random checks of serial_addsub across four WIDTH/DIGIT
// configurations driven from shared stimulus.
module tb_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [31:0] a_in;
    logic [31:0] b_in;

    logic        r81, b81, d81, c81, o81;
    logic [7:0]  s81;
    logic        r82, b82, d82, c82, o82;
    logic [7:0]  s82;
    logic        r164, b164, d164, c164, o164;
    logic [15:0] s164;
    logic        r328, b328, d328, c328, o328;
    logic [31:0] s328;

    int tests = 0;
    int fails = 0;
    int first81, first164, busy81_cnt;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u8_1 (
        .clock(clk), .reset(rst_n), .start(start), .sub(sub),
        .A(a_in[7:0]), .B(b_in[7:0]), .ready(r81), .busy(b81), .done(d81),
        .sum(s81), .carry_out(c81), .overflow(o81));

    serial_addsub #(.WIDTH(8), .DIGIT(2)) u8_2 (
        .clock(clk), .reset(rst_n), .start(start), .sub(sub),
        .A(a_in[7:0]), .B(b_in[7:0]), .ready(r82), .busy(b82), .done(d82),
        .sum(s82), .carry_out(c82), .overflow(o82));

    serial_addsub #(.WIDTH(16), .DIGIT(4)) u16_4 (
        .clock(clk), .reset(rst_n), .start(start), .sub(sub),
        .A(a_in[15:0]), .B(b_in[15:0]), .ready(r164), .busy(b164), .done(d164),
        .sum(s164), .carry_out(c164), .overflow(o164));

    serial_addsub #(.WIDTH(32), .DIGIT(8)) u32_8 (
        .clock(clk), .reset(rst_n), .start(start), .sub(sub),
        .A(a_in), .B(b_in), .ready(r328), .busy(b328), .done(d328),
        .sum(s328), .carry_out(c328), .overflow(o328));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full-width reference: returns {overflow, carry_out, sum}.
    function automatic logic [33:0] ref_op(input int w, input logic [31:0] a,
                                           input logic [31:0] b, input logic s);
        logic [32:0] mask, am, bm, t, r;
        logic        ov;
        mask = (33'd1 << w) - 33'd1;
        am   = {1'b0, a} & mask;
        bm   = (s ? {1'b0, ~b} : {1'b0, b}) & mask;
        t    = am + bm + {32'd0, s};
        r    = t & mask;
        ov   = (am[w-1] == bm[w-1]) && (r[w-1] != am[w-1]);
        return {ov, t[w], r[31:0]};
    endfunction

    // Accept at E0, then watch 12 more edges; done edges counted including E0.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        a_in = a; b_in = b; sub = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        first81 = 0; first164 = 0;
        busy81_cnt = b81 ? 1 : 0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); #1;
            if (d81 && first81 == 0)   first81  = e + 1;
            if (d164 && first164 == 0) first164 = e + 1;
            if (b81) busy81_cnt++;
        end
        $display("[TB] op A=0x%08h B=0x%08h sub=%0d -> s81=0x%02h s164=0x%04h s328=0x%08h",
                 a, b, s, s81, s164, s328);
    endtask

    task automatic check_rand(input string tag, input int w, input logic [31:0] a,
                              input logic [31:0] b, input logic s, input logic [31:0] gs,
                              input logic gc, input logic go);
        logic [33:0] e;
        e = ref_op(w, a, b, s);
        check({tag, "_sum"}, gs, e[31:0]);
        check({tag, "_cout"}, {31'd0, gc}, {31'd0, e[32]});
        check({tag, "_ovf"}, {31'd0, go}, {31'd0, e[33]});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        int          cnt;
        bit          got;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a_in = '0; b_in = '0;
        #12;
        check("rst_ready", {31'd0, r81}, 32'd1);
        check("rst_busy",  {31'd0, b81}, 32'd0);
        check("rst_done",  {31'd0, d81}, 32'd0);
        check("rst_sum",   {24'd0, s81}, 32'd0);
        check("rst_cout",  {31'd0, c81}, 32'd0);
        check("rst_ovf",   {31'd0, o81}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(32'h5A, 32'h3C, 1'b0);
        check("add_sum",   {24'd0, s81}, 32'h96);
        check("add_cout",  {31'd0, c81}, 32'd0);
        check("add_ovf",   {31'd0, o81}, 32'd1);
        check("add_lat",   first81, 32'd9);
        check("add_busy",  busy81_cnt, 32'd8);

        do_op(32'h10, 32'h20, 1'b1);
        check("sub1_sum",  {24'd0, s81}, 32'hF0);
        check("sub1_cout", {31'd0, c81}, 32'd0);
        check("sub1_ovf",  {31'd0, o81}, 32'd0);

        do_op(32'h80, 32'h01, 1'b1);
        check("sub2_sum",  {24'd0, s81}, 32'h7F);
        check("sub2_cout", {31'd0, c81}, 32'd1);
        check("sub2_ovf",  {31'd0, o81}, 32'd1);

        // Starts during RUN and DONE must be ignored.
        @(negedge clk);
        a_in = 32'h12; b_in = 32'h34; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ign_rdy_run", {31'd0, r81}, 32'd0);
        check("ign_hold",    {24'd0, s81}, 32'h7F);
        a_in = 32'hFF; b_in = 32'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk); #1;
            if (d81) got = 1'b1;
        end
        check("ign_done_seen", {31'd0, got}, 32'd1);
        check("ign_rdy_done",  {31'd0, r81}, 32'd0);
        a_in = 32'h77; b_in = 32'h11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ign_idle",   {31'd0, r81}, 32'd1);
        check("ign_result", {24'd0, s81}, 32'h46);
        @(negedge clk);
        a_in = 32'h01; b_in = 32'h02; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ign_accept", {31'd0, b81}, 32'd1);
        repeat (12) @(posedge clk);
        #1;
        check("ign_next_sum", {24'd0, s81}, 32'h03);
        $display("[TB] ignore sequence -> s81=0x%02h", s81);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        a_in = 32'h5A; b_in = 32'h3C; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sum",   {24'd0, s81}, 32'd0);
        check("arst_s328",  s328, 32'd0);
        check("arst_ovf",   {31'd0, o81}, 32'd0);
        check("arst_done",  {31'd0, d81}, 32'd0);
        check("arst_ready", {31'd0, r81}, 32'd1);
        check("arst_busy",  {31'd0, b81}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (d81 || d82 || d164 || d328) cnt++;
        end
        check("arst_no_done", cnt, 32'd0);
        do_op(32'hC8, 32'h64, 1'b1);
        check("post_sum",  {24'd0, s81}, 32'h64);
        check("post_cout", {31'd0, c81}, 32'd1);
        check("post_ovf",  {31'd0, o81}, 32'd1);

        do_op(32'hFFFF, 32'h0001, 1'b0);
        check("w16_sum",  {16'd0, s164}, 32'h0000);
        check("w16_cout", {31'd0, c164}, 32'd1);
        check("w16_ovf",  {31'd0, o164}, 32'd0);
        check("w16_lat",  first164, 32'd5);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            do_op(ra, rb, rs);
            check_rand("r8_1",  8,  ra, rb, rs, {24'd0, s81},  c81,  o81);
            check_rand("r8_2",  8,  ra, rb, rs, {24'd0, s82},  c82,  o82);
            check_rand("r16_4", 16, ra, rb, rs, {16'd0, s164}, c164, o164);
            check_rand("r32_8", 32, ra, rb, rs, s328,          c328, o328);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, handshaked serial adder/subtractor. It replaces the fixed 8-bit, 1-bit-per-cycle, free-running serial adder.
- Loads two WIDTH-bit operands on a start request. Processes DIGIT bits per clock, LSB first, with a registered carry.
- Returns sum, carry-out and signed overflow with a one-cycle done pulse.
- Used in area-constrained datapaths where a full-width adder is not justified.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per clock; must divide WIDTH exactly. Elaboration error otherwise.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when ready=1.
- sub  input  1  0 = A+B, 1 = A−B; captured with start.
- A  input  WIDTH  operand A; captured with start.
- B  input  WIDTH  operand B; captured with start.
- ready  output  1  high in IDLE; start accepted this cycle.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; result outputs valid and stable from this cycle on.
- sum  output  WIDTH  result register.
- carry_out  output  1  final carry. For sub this is the no-borrow flag (1 when A ≥ B unsigned).
- overflow  output  1  two's-complement signed overflow of the operation.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state = IDLE; ready=1, busy=0, done=0;
  - sum=0, carry_out=0, overflow=0;
  - internal shift registers, carry and digit counter = 0.
- Reset mid-operation aborts silently: no done pulse, results cleared.
- States IDLE → RUN → DONE → IDLE. Let N = WIDTH/DIGIT.
- IDLE, edge with start=1:
  - capture A into shift reg SA;
  - capture B into shift reg SB, or ~B when sub=1;
  - carry = sub;
  - counter = N−1; go to RUN.
  - start=0: stay in IDLE; outputs hold.
- RUN, each edge:
  - compute the DIGIT-bit sum of SA[DIGIT-1:0] + SB[DIGIT-1:0] + carry;
  - shift the digit into the MSB end of the partial-result register; shift SA and SB right by DIGIT;
  - update carry.
  - Track the carry into the MSB; it is needed for overflow.
  - If counter==0: copy the partial result to sum, set carry_out = final carry, set overflow = carry into MSB XOR carry out of MSB, go to DONE. Otherwise decrement counter.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- The sum, carry_out and overflow outputs change only on the RUN→DONE edge. They hold the previous result throughout RUN and until the next completion.
- Latency: start sampled at edge E0; done is high in the cycle following edge EN, i.e. N+1 edges after acceptance. Throughput is one operation per N+2 cycles.
- start asserted in RUN or DONE is ignored and not queued. A, B and sub may change freely after acceptance.
- Arithmetic is modulo 2^WIDTH. Subtraction is A + ~B + 1.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state encoding typedef (IDLE, RUN, DONE);
  - localparam helper for N and the counter width, clog2(N) with a minimum of 1.
- One sub-module, serial_digit_adder, parametrised by DIGIT:
  - combinational DIGIT-bit ripple slice;
  - inputs a, b, cin;
  - outputs s, cout, and c_msb_in (carry into the slice MSB).
  - This makes overflow extraction uniform for any DIGIT.

Test Plan:
- WIDTH=8, DIGIT=1, sub=0, A=0x5A, B=0x3C → sum=0x96, carry_out=0, overflow=1. done exactly 9 edges after the accepting edge; busy high for 8 cycles.
- WIDTH=8, DIGIT=1, sub=1, A=0x10, B=0x20 → sum=0xF0, carry_out=0, overflow=0. Then A=0x80, B=0x01, sub=1 → sum=0x7F, carry_out=1, overflow=1.
- WIDTH=16, DIGIT=4, sub=0, A=0xFFFF, B=0x0001 → sum=0x0000, carry_out=1, overflow=0. done 5 edges after acceptance.
- Start pulsed with new operands during RUN and again during DONE → ignored. Only the first result appears; ready=0 in those cycles; a start in the following IDLE cycle is accepted.
- Assert reset=0 asynchronously mid-RUN (between edges) → sum, carry_out, overflow and done go to 0 immediately, ready=1. No done pulse after release; the next operation completes correctly.
- Random regression over (WIDTH, DIGIT) ∈ {(8,1), (8,2), (16,4), (32,8)} with random A, B, sub, compared against a full-width reference model for all three result fields.
